// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel line-buffer path.
//   IMG_W / IMG_H   : frame geometry (pixels per row / rows per frame)
//   ADDR_W / ROW_W  : line-buffer address / column counter width, row counter width
//   pixel_t         : 8-bit grayscale pixel
//   col_word_t      : one vertical 3-pixel column with position and border flags
//   fifo_ptr_inc    : wrap-around increment for the 3-entry column FIFO pointers
package sobel_pkg;

  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned ROW_W      = 8;
  localparam int unsigned FIFO_DEPTH = 3;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    pixel_t              top;
    pixel_t              mid;
    pixel_t              bot;
    logic [ADDR_W-1:0]   col;
    logic [ROW_W-1:0]    row;
    logic                eol;
    logic                eof;
  } col_word_t;

  function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/linebuf_ctrl_if.sv
// Bus bundle for linebuf_ctrl: pixel input stream, line-buffer RAM port
// and column output stream.
//   master : controller view (drives in_ready, lb_*, out_* except out_ready)
//   slave  : environment view (pixel source, the two RAMs, column sink)
interface linebuf_ctrl_if;
  import sobel_pkg::*;

  logic              in_valid;
  logic              in_ready;
  pixel_t            in_pixel;
  logic              in_sof;

  logic [1:0]        lb_we;
  logic [ADDR_W-1:0] lb_waddr;
  pixel_t            lb_din;
  logic [ADDR_W-1:0] lb_raddr;
  pixel_t            lb0_dout;
  pixel_t            lb1_dout;

  logic              out_valid;
  logic              out_ready;
  pixel_t            out_top;
  pixel_t            out_mid;
  pixel_t            out_bot;
  logic [ADDR_W-1:0] out_col;
  logic [ROW_W-1:0]  out_row;
  logic              out_eol;
  logic              out_eof;

  modport master (
    input  in_valid, in_pixel, in_sof, lb0_dout, lb1_dout, out_ready,
    output in_ready, lb_we, lb_waddr, lb_din, lb_raddr,
           out_valid, out_top, out_mid, out_bot, out_col, out_row, out_eol, out_eof
  );

  modport slave (
    output in_valid, in_pixel, in_sof, lb0_dout, lb1_dout, out_ready,
    input  in_ready, lb_we, lb_waddr, lb_din, lb_raddr,
           out_valid, out_top, out_mid, out_bot, out_col, out_row, out_eol, out_eof
  );

endinterface

// File: rtl/col_skid_fifo.sv
// 3-entry column FIFO between the S1 stage and the column output.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (caller guarantees room)
//   i_pop      : remove head (ignored when empty)
//   o_head     : head entry (all-zero when empty after reset)
//   o_count    : number of stored entries, 0..3
module col_skid_fifo
  import sobel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  col_word_t  i_data,
  input  logic       i_pop,
  output col_word_t  o_head,
  output logic [1:0] o_count
);

  col_word_t  r_mem [FIFO_DEPTH];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count < 2'(FIFO_DEPTH)) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= fifo_ptr_inc(r_wp);
      end
      if (w_pop) r_rp <= fifo_ptr_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_count;

endmodule

// File: rtl/linebuf_ctrl.sv
// Line-buffer sequencer for the Sobel path. Accepts a raster pixel stream and
// emits one vertical column (rows r-2, r-1, r) per accepted pixel using two
// external 320x8 read-first RAMs with 1-cycle read latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : linebuf_ctrl_if.master (in_* stream, lb_* RAM port, out_* stream)
// Optional build macro LINEBUF_EDGE_REPLICATE_EN: rows 0/1 replicate the
// nearest valid row instead of forcing missing rows to zero.
module linebuf_ctrl
  import sobel_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  linebuf_ctrl_if.master bus
);

  logic [ADDR_W-1:0] r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  pixel_t            r_din;

  logic              r_s1_valid;
  pixel_t            r_s1_pix;
  logic [ADDR_W-1:0] r_s1_col;
  logic [ROW_W-1:0]  r_s1_row;
  logic              r_s1_sel;

  logic              w_accept;
  logic [ADDR_W-1:0] w_col_cur;
  logic [ROW_W-1:0]  w_row_cur;
  logic              w_last_col;
  logic              w_last_row;
  logic [2:0]        w_occupancy;
  logic [1:0]        w_fifo_count;
  col_word_t         w_word;
  col_word_t         w_head;
  pixel_t            w_rd_old;
  pixel_t            w_rd_prev;

  // sof restarts the frame at the pixel that carries it
  assign w_col_cur  = bus.in_sof ? '0 : r_col;
  assign w_row_cur  = bus.in_sof ? '0 : r_row;
  assign w_last_col = (w_col_cur == ADDR_W'(IMG_W - 1));
  assign w_last_row = (w_row_cur == ROW_W'(IMG_H - 1));

  // Counts words already in flight so the FIFO can never overflow even
  // without looking at a same-cycle pop.
  assign w_occupancy  = {1'b0, w_fifo_count} + {2'b00, r_s1_valid};
  assign bus.in_ready = rst_n & (w_occupancy < 3'(FIFO_DEPTH));
  assign w_accept     = bus.in_valid & bus.in_ready;

  assign bus.lb_we    = w_accept ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.lb_waddr = w_accept ? w_col_cur : r_addr;
  assign bus.lb_raddr = w_accept ? w_col_cur : r_addr;
  assign bus.lb_din   = w_accept ? bus.in_pixel : r_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
      r_s1_sel   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_addr   <= w_col_cur;
        r_din    <= bus.in_pixel;
        r_s1_pix <= bus.in_pixel;
        r_s1_col <= w_col_cur;
        r_s1_row <= w_row_cur;
        r_s1_sel <= r_sel;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : w_row_cur + ROW_W'(1);
          r_sel <= ~r_sel;
        end else begin
          r_col <= w_col_cur + ADDR_W'(1);
          r_row <= w_row_cur;
        end
      end
    end
  end

  // buffer[sel] was just overwritten read-first, so its dout is row r-2
  assign w_rd_old  = r_s1_sel ? bus.lb1_dout : bus.lb0_dout;
  assign w_rd_prev = r_s1_sel ? bus.lb0_dout : bus.lb1_dout;

  always_comb begin
    w_word     = '0;
    w_word.bot = r_s1_pix;
    w_word.mid = w_rd_prev;
    w_word.top = w_rd_old;
`ifdef LINEBUF_EDGE_REPLICATE_EN
    if (r_s1_row == ROW_W'(0)) begin
      w_word.top = r_s1_pix;
      w_word.mid = r_s1_pix;
    end else if (r_s1_row == ROW_W'(1)) begin
      w_word.top = w_rd_prev;
    end
`else
    if (r_s1_row < ROW_W'(2)) w_word.top = '0;
    if (r_s1_row == ROW_W'(0)) w_word.mid = '0;
`endif
    w_word.col = r_s1_col;
    w_word.row = r_s1_row;
    w_word.eol = (r_s1_col == ADDR_W'(IMG_W - 1));
    w_word.eof = w_word.eol & (r_s1_row == ROW_W'(IMG_H - 1));
  end

  col_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s1_valid),
    .i_data  (w_word),
    .i_pop   (bus.out_valid & bus.out_ready),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  assign bus.out_valid = (w_fifo_count != 2'd0);
  assign bus.out_top   = w_head.top;
  assign bus.out_mid   = w_head.mid;
  assign bus.out_bot   = w_head.bot;
  assign bus.out_col   = w_head.col;
  assign bus.out_row   = w_head.row;
  assign bus.out_eol   = w_head.eol;
  assign bus.out_eof   = w_head.eof;

endmodule

// File: tb/tb_linebuf_ctrl.sv
`timescale 1ns/1ps
module tb_linebuf_ctrl;
  import sobel_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  linebuf_ctrl_if bus();

  linebuf_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // two behavioural read-first RAMs, 1-cycle read latency
  pixel_t ram0 [IMG_W];
  pixel_t ram1 [IMG_W];
  always @(posedge clk) begin
    if (bus.lb_we[0]) ram0[bus.lb_waddr] <= bus.lb_din;
    if (bus.lb_we[1]) ram1[bus.lb_waddr] <= bus.lb_din;
    bus.lb0_dout <= ram0[bus.lb_raddr];
    bus.lb1_dout <= ram1[bus.lb_raddr];
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // monitor: columns leaving, lb_we of each accept
  col_word_t   col_q [$];
  int unsigned stamp_q [$];
  logic [1:0]  we_q [$];
  col_word_t   mon_w;
  int unsigned cyc   = 0;
  int unsigned n_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      mon_w.top = bus.out_top; mon_w.mid = bus.out_mid; mon_w.bot = bus.out_bot;
      mon_w.col = bus.out_col; mon_w.row = bus.out_row;
      mon_w.eol = bus.out_eol; mon_w.eof = bus.out_eof;
      col_q.push_back(mon_w);
      stamp_q.push_back(cyc);
    end
    if (rst_n && bus.in_valid && bus.in_ready) begin
      we_q.push_back(bus.lb_we);
      n_acc++;
    end
  end

  function automatic pixel_t ramp_px(input int r, input int c);
    return pixel_t'((r * 3 + c) & 255);
  endfunction

  function automatic col_word_t exp_ramp(input int r, input int c);
    col_word_t e;
    e.bot = ramp_px(r, c);
    e.mid = (r >= 1) ? ramp_px(r - 1, c) : 8'h00;
    e.top = (r >= 2) ? ramp_px(r - 2, c) : 8'h00;
`ifdef LINEBUF_EDGE_REPLICATE_EN
    if (r == 0) begin e.top = e.bot; e.mid = e.bot; end
    else if (r == 1) e.top = e.mid;
`else
    if (r < 2) e.top = 8'h00;
    if (r == 0) e.mid = 8'h00;
`endif
    e.col = ADDR_W'(c);
    e.row = ROW_W'(r);
    e.eol = (c == IMG_W - 1);
    e.eof = e.eol && (r == IMG_H - 1);
    return e;
  endfunction

  task automatic do_reset;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_pixel = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_px(input pixel_t p, input logic sof, output bit ok, output int unsigned st);
    logic rdy;
    bus.in_valid = 1'b1; bus.in_pixel = p; bus.in_sof = sof;
    ok = 1'b0; st = 0;
    for (int unsigned g = 0; g < 200 && !ok; g++) begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1; else st++;
    end
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic stream_ramp(input int unsigned npx, output int unsigned n_to, output int unsigned n_st);
    bit ok;
    int unsigned st;
    n_to = 0; n_st = 0;
    for (int unsigned i = 0; i < npx; i++) begin
      push_px(ramp_px(int'((i / IMG_W) % IMG_H), int'(i % IMG_W)), (i == 0), ok, st);
      if (!ok) n_to++;
      n_st += st;
    end
  endtask

  task automatic drain(input int unsigned target);
    for (int i = 0; i < 200 && col_q.size() < target; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_pixel = 8'h55; bus.in_sof = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.lb_we} !== 4'b0000) begin
      n_err++; $display("FAIL reset_held: {in_ready,out_valid,lb_we}=%b exp 0000", {bus.in_ready, bus.out_valid, bus.lb_we});
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.lb_we} !== 4'b1000) begin
      n_err++; $display("FAIL reset_release: {in_ready,out_valid,lb_we}=%b exp 1000", {bus.in_ready, bus.out_valid, bus.lb_we});
    end
  endtask

  task automatic test_first_accept;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_pixel = 8'h11; bus.in_sof = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.lb_we, bus.lb_waddr, bus.lb_din} !== {2'b01, 9'd0, 8'h11}) begin
      n_err++; $display("FAIL first_write: we=%b waddr=%0d din=%h exp we=01 waddr=0 din=11", bus.lb_we, bus.lb_waddr, bus.lb_din);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL first_early: out_valid=%b exp 0 one clk after accept", bus.out_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.out_valid, bus.out_bot, bus.out_col, bus.out_row} !== {1'b1, 8'h11, 9'd0, 8'd0}) begin
      n_err++; $display("FAIL first_out: valid=%b bot=%h col=%0d row=%0d exp 1 11 0 0", bus.out_valid, bus.out_bot, bus.out_col, bus.out_row);
    end
    n_vec++;
    if (bus.lb_we !== 2'b00) begin
      n_err++; $display("FAIL idle_we: lb_we=%b exp 00", bus.lb_we);
    end
  endtask

  int ramp_base = 0;

  task automatic test_ramp;
    int unsigned to, st, errs, gaps;
    int base, idx;
    col_word_t e;
    do_reset();
    bus.out_ready = 1'b1;
    base = col_q.size();
    ramp_base = base;
    stream_ramp(6 * IMG_W, to, st);
    drain(base + 6 * IMG_W);
    n_vec++;
    if (to !== 0 || st !== 0) begin
      n_err++; $display("FAIL ramp_in_stall: timeouts=%0d stalls=%0d exp 0 0", to, st);
    end
    n_vec++;
    if (col_q.size() !== base + 6 * IMG_W) begin
      n_err++; $display("FAIL ramp_count: got %0d cols exp %0d", col_q.size() - base, 6 * IMG_W);
    end
    errs = 0;
    for (int i = 0; i < 6 * int'(IMG_W); i++) begin
      e = exp_ramp(i / IMG_W, i % IMG_W);
      if (col_q[base + i] !== e) begin
        if (errs == 0) $display("FAIL ramp_col idx %0d: got %h exp %h", i, col_q[base + i], e);
        errs++;
      end
    end
    n_vec++;
    if (errs != 0) begin
      n_err++; $display("FAIL ramp_data: %0d bad columns exp 0", errs);
    end
    idx = base + 5 * IMG_W + 7;
    n_vec++;
    if ({col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== 24'h10_13_16) begin
      n_err++; $display("FAIL ramp_r5c7: got %h%h%h exp 101316", col_q[idx].top, col_q[idx].mid, col_q[idx].bot);
    end
    idx = base + 3;
    n_vec++;
`ifdef LINEBUF_EDGE_REPLICATE_EN
    if ({col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== 24'h03_03_03) begin
      n_err++; $display("FAIL border_r0: got %h%h%h exp 030303", col_q[idx].top, col_q[idx].mid, col_q[idx].bot);
    end
`else
    if ({col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== 24'h00_00_03) begin
      n_err++; $display("FAIL border_r0: got %h%h%h exp 000003", col_q[idx].top, col_q[idx].mid, col_q[idx].bot);
    end
`endif
    idx = base + IMG_W + 3;
    n_vec++;
`ifdef LINEBUF_EDGE_REPLICATE_EN
    if ({col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== 24'h03_03_06) begin
      n_err++; $display("FAIL border_r1: got %h%h%h exp 030306", col_q[idx].top, col_q[idx].mid, col_q[idx].bot);
    end
`else
    if ({col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== 24'h00_03_06) begin
      n_err++; $display("FAIL border_r1: got %h%h%h exp 000306", col_q[idx].top, col_q[idx].mid, col_q[idx].bot);
    end
`endif
    gaps = 0;
    for (int i = 1; i < 6 * int'(IMG_W); i++)
      if (stamp_q[base + i] != stamp_q[base + i - 1] + 1) gaps++;
    n_vec++;
    if (gaps != 0) begin
      n_err++; $display("FAIL ramp_throughput: %0d output gaps exp 0", gaps);
    end
  endtask

  task automatic test_backpressure;
    int unsigned to, st, errs, a0, a1, a2;
    int base;
    logic rdy_low;
    do_reset();
    bus.out_ready = 1'b1;
    base = col_q.size();
    a0 = n_acc; a1 = 0; a2 = 0; rdy_low = 1'b0;
    fork
      stream_ramp(6 * IMG_W, to, st);
      begin
        for (int i = 0; i < 5000 && n_acc < a0 + 1300; i++) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        a1 = n_acc;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rdy_low = ~bus.in_ready;
        a2 = n_acc;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain(base + 6 * IMG_W);
    n_vec++;
    if (a2 - a1 > 3 || !rdy_low) begin
      n_err++; $display("FAIL bp_stall: accepts during stall=%0d in_ready_low=%b exp <=3 1", a2 - a1, rdy_low);
    end
    n_vec++;
    if (to !== 0 || col_q.size() !== base + 6 * IMG_W) begin
      n_err++; $display("FAIL bp_count: timeouts=%0d cols=%0d exp 0 %0d", to, col_q.size() - base, 6 * IMG_W);
    end
    errs = 0;
    for (int i = 0; i < 6 * int'(IMG_W); i++) begin
      if (col_q[base + i] !== col_q[ramp_base + i]) begin
        if (errs == 0) $display("FAIL bp_col idx %0d: got %h exp %h", i, col_q[base + i], col_q[ramp_base + i]);
        errs++;
      end
    end
    n_vec++;
    if (errs != 0) begin
      n_err++; $display("FAIL bp_sequence: %0d columns differ from no-stall run exp 0", errs);
    end
  endtask

  task automatic test_wrap;
    int unsigned to, st, neof;
    int base, wbase, last;
    do_reset();
    bus.out_ready = 1'b1;
    base  = col_q.size();
    wbase = we_q.size();
    last  = IMG_W * IMG_H - 1;
    stream_ramp(IMG_W * IMG_H + 2, to, st);
    drain(base + IMG_W * IMG_H + 2);
    n_vec++;
    if (to !== 0 || col_q.size() !== base + IMG_W * IMG_H + 2) begin
      n_err++; $display("FAIL wrap_count: timeouts=%0d cols=%0d exp 0 %0d", to, col_q.size() - base, IMG_W * IMG_H + 2);
    end
    n_vec++;
    if ({col_q[base + 319].eol, col_q[base + 319].eof, col_q[base + 319].col, col_q[base + 319].row} !== {1'b1, 1'b0, 9'd319, 8'd0}) begin
      n_err++; $display("FAIL wrap_eol: eol=%b eof=%b col=%0d row=%0d exp 1 0 319 0", col_q[base + 319].eol, col_q[base + 319].eof, col_q[base + 319].col, col_q[base + 319].row);
    end
    n_vec++;
    if ({we_q[wbase + 319], we_q[wbase + 320], we_q[wbase + 640]} !== 6'b01_10_01) begin
      n_err++; $display("FAIL wrap_sel: we=%b %b %b exp 01 10 01", we_q[wbase + 319], we_q[wbase + 320], we_q[wbase + 640]);
    end
    n_vec++;
    if ({col_q[base + 320].col, col_q[base + 320].row} !== {9'd0, 8'd1}) begin
      n_err++; $display("FAIL wrap_row: col=%0d row=%0d exp 0 1", col_q[base + 320].col, col_q[base + 320].row);
    end
    n_vec++;
    if ({col_q[base + last].eol, col_q[base + last].eof, col_q[base + last].col, col_q[base + last].row} !== {1'b1, 1'b1, 9'd319, 8'd239}) begin
      n_err++; $display("FAIL wrap_eof: eol=%b eof=%b col=%0d row=%0d exp 1 1 319 239", col_q[base + last].eol, col_q[base + last].eof, col_q[base + last].col, col_q[base + last].row);
    end
    n_vec++;
    if ({col_q[base + last + 1].col, col_q[base + last + 1].row, col_q[base + last + 1].eof,
         col_q[base + last + 2].col, col_q[base + last + 2].row, we_q[wbase + last + 1]} !== {9'd0, 8'd0, 1'b0, 9'd1, 8'd0, 2'b01}) begin
      n_err++; $display("FAIL wrap_frame: next=(%0d,%0d eof %b) then (%0d,%0d) we=%b exp (0,0 eof 0) then (1,0) we=01",
        col_q[base + last + 1].col, col_q[base + last + 1].row, col_q[base + last + 1].eof,
        col_q[base + last + 2].col, col_q[base + last + 2].row, we_q[wbase + last + 1]);
    end
    neof = 0;
    for (int i = 0; i < IMG_W * IMG_H + 2; i++) if (col_q[base + i].eof) neof++;
    n_vec++;
    if (neof != 1) begin
      n_err++; $display("FAIL wrap_eof_count: got %0d exp 1", neof);
    end
  endtask

  task automatic test_sof;
    int unsigned to, st, st2;
    int base, idx;
    bit ok1, ok2, ok3;
    do_reset();
    bus.out_ready = 1'b1;
    base = col_q.size();
    stream_ramp(3 * IMG_W + 100, to, st);
    push_px(8'hA5, 1'b1, ok1, st2);
    push_px(8'hB6, 1'b0, ok2, st2);
    push_px(8'hC7, 1'b0, ok3, st2);
    drain(base + 3 * IMG_W + 103);
    idx = base + 3 * IMG_W + 100;
    n_vec++;
    if (!(ok1 && ok2 && ok3) || to !== 0 || col_q.size() !== base + 3 * IMG_W + 103) begin
      n_err++; $display("FAIL sof_count: cols=%0d exp %0d", col_q.size() - base, 3 * IMG_W + 103);
    end
    n_vec++;
    if ({col_q[idx - 1].col, col_q[idx - 1].row} !== {9'd99, 8'd3}) begin
      n_err++; $display("FAIL sof_before: col=%0d row=%0d exp 99 3", col_q[idx - 1].col, col_q[idx - 1].row);
    end
    n_vec++;
`ifdef LINEBUF_EDGE_REPLICATE_EN
    if ({col_q[idx].col, col_q[idx].row, col_q[idx].eol, col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== {9'd0, 8'd0, 1'b0, 24'hA5_A5_A5}) begin
`else
    if ({col_q[idx].col, col_q[idx].row, col_q[idx].eol, col_q[idx].top, col_q[idx].mid, col_q[idx].bot} !== {9'd0, 8'd0, 1'b0, 24'h00_00_A5}) begin
`endif
      n_err++; $display("FAIL sof_pixel: col=%0d row=%0d eol=%b tmb=%h%h%h", col_q[idx].col, col_q[idx].row, col_q[idx].eol, col_q[idx].top, col_q[idx].mid, col_q[idx].bot);
    end
    n_vec++;
`ifdef LINEBUF_EDGE_REPLICATE_EN
    if ({col_q[idx + 1].col, col_q[idx + 1].row, col_q[idx + 1].top, col_q[idx + 1].mid, col_q[idx + 1].bot} !== {9'd1, 8'd0, 24'hB6_B6_B6}) begin
`else
    if ({col_q[idx + 1].col, col_q[idx + 1].row, col_q[idx + 1].top, col_q[idx + 1].mid, col_q[idx + 1].bot} !== {9'd1, 8'd0, 24'h00_00_B6}) begin
`endif
      n_err++; $display("FAIL sof_next: col=%0d row=%0d tmb=%h%h%h", col_q[idx + 1].col, col_q[idx + 1].row, col_q[idx + 1].top, col_q[idx + 1].mid, col_q[idx + 1].bot);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    int unsigned st;
    do_reset();
    bus.out_ready = 1'b0;
    push_px(8'h21, 1'b1, ok, st);
    push_px(8'h22, 1'b0, ok, st);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: out_valid=%b exp 1", bus.out_valid);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.lb_we, bus.out_bot} !== 12'h000) begin
      n_err++; $display("FAIL arst_clear: valid=%b ready=%b we=%b bot=%h exp 0 0 00 00", bus.out_valid, bus.in_ready, bus.lb_we, bus.out_bot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_pixel = '0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
    test_reset();
    test_first_accept();
    test_ramp();
    test_backpressure();
    test_sof();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
